// File: rtl/pc_gen_unit.sv
// Program-counter generator for a fetch/decode front end.
// It tracks the IF fetch address and the PC of the instruction in ID.
// It resolves exception, eret, branch and jump redirects by fixed priority.
// A redirect that arrives during a stall is buffered until the stall releases.
// A redirect target that is not STEP-aligned is diverted to the exception vector.
module pc_gen_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 'h0040_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h0040_0004,
  parameter int unsigned      STEP         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc,
  input  logic             eret,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] id_pc,
  output logic             id_valid,
  output logic [WIDTH-1:0] epc,
  output logic             pending,
  output logic             misalign
);

  // Low address bits that must be zero for a STEP-aligned target (STEP is a power of two).
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_id_pc;
  logic             r_id_valid;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] r_ptgt;
  logic             r_misalign;

  logic             w_redir;
  logic [WIDTH-1:0] w_raw_tgt;
  logic             w_misal;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_pc_plus;

  // Select the non-exception redirect target by priority and screen it for alignment.
  always_comb begin
    w_redir   = eret | br_taken | jmp;
    w_raw_tgt = '0;
    if (eret)          w_raw_tgt = r_epc;
    else if (br_taken) w_raw_tgt = br_target;
    else if (jmp)      w_raw_tgt = jmp_target;
    // An exception in the same cycle wins, so misalignment is not reported then.
    w_misal   = w_redir && !exc && ((w_raw_tgt & ALIGN_MASK) != '0);
    w_tgt     = w_misal ? EXC_VECTOR : w_raw_tgt;
    w_pc_plus = r_pc + WIDTH'(STEP);
  end

  // RUN/HOLD state machine together with the PC, ID-slot, EPC and pending-target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_VECTOR;
      r_id_pc    <= RESET_VECTOR;
      r_id_valid <= 1'b0;
      r_epc      <= '0;
      r_ptgt     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (exc) begin
        // Exceptions ignore stall and flush any buffered redirect.
        r_pc       <= EXC_VECTOR;
        r_epc      <= r_id_pc;
        r_id_valid <= 1'b0;
        r_ptgt     <= '0;
        r_state    <= S_RUN;
      end else begin
        if (w_misal) begin
          r_misalign <= 1'b1;
          r_epc      <= w_raw_tgt;
          r_id_valid <= 1'b0;
        end
        if (stall) begin
          // Frozen: only capture a newly arriving redirect (latest one wins).
          if (w_redir) begin
            r_ptgt  <= w_tgt;
            r_state <= S_HOLD;
          end
        end else if (w_redir) begin
          r_pc       <= w_tgt;
          r_id_valid <= 1'b0;
          r_state    <= S_RUN;
        end else if (r_state == S_HOLD) begin
          r_pc       <= r_ptgt;
          r_id_valid <= 1'b0;
          r_state    <= S_RUN;
        end else begin
          r_pc       <= w_pc_plus;
          r_id_pc    <= r_pc;
          r_id_valid <= 1'b1;
        end
      end
    end
  end

  assign pc       = r_pc;
  assign pc_plus  = w_pc_plus;
  assign id_pc    = r_id_pc;
  assign id_valid = r_id_valid;
  assign epc      = r_epc;
  assign pending  = (r_state == S_HOLD);
  assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios plus randomized redirects/stalls.
module tb_pc_gen_unit;

  localparam logic [31:0] RV  = 32'h0040_0000;
  localparam logic [31:0] EXV = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, exc = 1'b0, eret = 1'b0, br_taken = 1'b0, jmp = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0;
  logic [31:0] pc, pc_plus, id_pc, epc;
  logic        id_valid, pending, misalign;

  pc_gen_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .exc(exc), .eret(eret),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .pc(pc), .pc_plus(pc_plus), .id_pc(id_pc), .id_valid(id_valid),
    .epc(epc), .pending(pending), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] epc;
    logic [31:0] ptgt;
    bit          id_valid;
    bit          pending;
    bit          misalign;
  } st_t;

  st_t m;
  st_t exp_q[$];
  bit  mon_en = 1'b0;
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  function automatic st_t reset_state();
    st_t s;
    s.pc = RV; s.id_pc = RV; s.epc = '0; s.ptgt = '0;
    s.id_valid = 1'b0; s.pending = 1'b0; s.misalign = 1'b0;
    return s;
  endfunction

  // Behavioural reference: what the front end should look like after one clock edge.
  function automatic st_t step(input st_t s, input bit stl, input bit ex, input bit er,
                               input bit br, input logic [31:0] bt,
                               input bit jp, input logic [31:0] jt);
    st_t         n;
    bit          redir;
    logic [31:0] tgt;
    n = s;
    n.misalign = 1'b0;
    redir = er || br || jp;
    tgt = er ? s.epc : (br ? bt : (jp ? jt : 32'd0));
    if (ex) begin
      n.pc = EXV; n.epc = s.id_pc; n.id_valid = 1'b0; n.pending = 1'b0;
      return n;
    end
    if (redir && (tgt % 4 != 0)) begin
      n.misalign = 1'b1; n.epc = tgt; n.id_valid = 1'b0; tgt = EXV;
    end
    if (stl) begin
      if (redir) begin n.pending = 1'b1; n.ptgt = tgt; end
    end else if (redir) begin
      n.pc = tgt; n.id_valid = 1'b0; n.pending = 1'b0;
    end else if (s.pending) begin
      n.pc = s.ptgt; n.id_valid = 1'b0; n.pending = 1'b0;
    end else begin
      n.pc = s.pc + 32'd4; n.id_pc = s.pc; n.id_valid = 1'b1;
    end
    return n;
  endfunction

  // Drive one cycle of stimulus and enqueue the state expected after the coming edge.
  task automatic cycle(input bit stl, input bit ex, input bit er, input bit br,
                       input logic [31:0] bt, input bit jp, input logic [31:0] jt);
    stall = stl; exc = ex; eret = er; br_taken = br; br_target = bt; jmp = jp; jmp_target = jt;
    m = step(m, stl, ex, er, br, bt, jp, jt);
    exp_q.push_back(m);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle with noisy inputs; released one edge later.
  task automatic do_reset();
    mon_en = 1'b0;
    exp_q.delete();
    stall = 1'b1; jmp = 1'b1; jmp_target = 32'h0040_0800; exc = 1'b0; eret = 1'b0; br_taken = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_pc", pc, RV);
    chk("rst_id_pc", id_pc, RV);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_pc", pc, RV);
    #1;
    rst = 1'b0;
    stall = 1'b0; jmp = 1'b0; jmp_target = '0;
    m = reset_state();
    mon_en = 1'b1;
  endtask

  // Monitor: one output state per clock edge, compared against the queued expectation.
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus", pc_plus, e.pc + 32'd4);
        chk("id_pc", id_pc, e.id_pc);
        chk("id_valid", 32'(id_valid), 32'(e.id_valid));
        chk("epc", epc, e.epc);
        chk("pending", 32'(pending), 32'(e.pending));
        chk("misalign", 32'(misalign), 32'(e.misalign));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    case ($urandom_range(0, 9))
      0:       t = $urandom;
      1:       t = 32'hFFFF_FFFC;
      2:       t = 32'h0040_0002 + ($urandom_range(0, 63) << 2);
      default: t = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
    endcase
    return t;
  endfunction

  initial begin
    m = reset_state();
    @(posedge clk);
    #2;

    // Sequential fetch after reset.
    do_reset();
    idle(); idle(); idle();
    chk("seq_pc", pc, 32'h0040_000C);
    chk("seq_id_valid", 32'(id_valid), 32'd1);

    // Unstalled branch.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
    chk("br_pc", pc, 32'h0040_0100);
    chk("br_id_valid", 32'(id_valid), 32'd0);
    idle();
    chk("br_next_pc", pc, 32'h0040_0104);
    chk("br_next_valid", 32'(id_valid), 32'd1);

    // Redirects during a stall; the later one replaces the buffered target.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0200);
    chk("stall_pc1", pc, 32'h0040_0104);
    chk("stall_pend1", 32'(pending), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0300, 1'b0, 32'd0);
    chk("stall_pc2", pc, 32'h0040_0104);
    idle();
    chk("release_pc", pc, 32'h0040_0300);
    chk("release_pend", 32'(pending), 32'd0);

    // Exception under stall, then eret.
    do_reset();
    repeat (5) idle();
    chk("pre_exc_id_pc", id_pc, 32'h0040_0010);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("exc_pc", pc, EXV);
    chk("exc_epc", epc, 32'h0040_0010);
    chk("exc_id_valid", 32'(id_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("eret_pc", pc, 32'h0040_0010);

    // Misaligned jump.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0102);
    chk("mis_pc", pc, EXV);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_epc", epc, 32'h0040_0102);
    idle();
    chk("mis_pulse_end", 32'(misalign), 32'd0);

    // Exception and misaligned branch together.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0003, 1'b0, 32'd0);
    chk("exc_mis_flag", 32'(misalign), 32'd0);

    // Reset while a redirect is pending.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0200);
    chk("pre_rst_pend", 32'(pending), 32'd1);
    do_reset();
    idle();
    chk("post_rst_pc", pc, 32'h0040_0004);

    // Wrap of the fetch address past all-ones.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    idle();
    chk("wrap_pc", pc, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 4) < 2,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 5) == 0, rnd_tgt(),
              $urandom_range(0, 5) == 0, rnd_tgt());
      end
    end
    stall = 1'b0; exc = 1'b0; eret = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
